seven_seg_capture: RTL and testbench



---
 rtl/seven_seg_capture.sv | 219 +++++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: receive side of a multiplexed seven-segment display.
// Samples the active-low segment and anode lines. When a digit's segment
// pattern has been stable long enough, it decodes the pattern back to a hex
// nibble. A full word is published once every digit has been captured.
module seven_seg_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg,
  input  logic [DIGITS-1:0]   anodes,
  output logic [4*DIGITS-1:0] value,
  output logic                frame_strobe,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                decode_err,
  input  logic                err_clr
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = DIGITS + 7;
  localparam logic [7:0]    STABLE_THR  = 8'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  // Active-low abcdefg pattern to {legal, nibble}
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: return {1'b1, 4'h0};
      7'b1001111: return {1'b1, 4'h1};
      7'b0010010: return {1'b1, 4'h2};
      7'b0000110: return {1'b1, 4'h3};
      7'b1001100: return {1'b1, 4'h4};
      7'b0100100: return {1'b1, 4'h5};
      7'b0100000: return {1'b1, 4'h6};
      7'b0001111: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0000100: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b1100000: return {1'b1, 4'hB};
      7'b0110001: return {1'b1, 4'hC};
      7'b1000010: return {1'b1, 4'hD};
      7'b0110000: return {1'b1, 4'hE};
      7'b0111000: return {1'b1, 4'hF};
      default:    return 5'b0_0000;
    endcase
  endfunction

  logic [6:0]          seg_s1_reg, seg_s2_reg;
  logic [DIGITS-1:0]   an_s1_reg, an_s2_reg;
  logic [PW-1:0]       sample;
  logic [CW-1:0]       low_cnt;
  logic [KW-1:0]       sel_idx;
  logic                is_single, is_multi, sample_same;

  state_t              state_reg, state_next;
  logic [PW-1:0]       pair_reg, pair_next;
  logic [KW-1:0]       k_reg, k_next;
  logic [7:0]          cnt_reg, cnt_next, cnt_inc;
  logic                capture, load;

  logic [4:0]          dec;
  logic                cap_ok, err_set, frame_done, timeout_hit;
  logic [TW-1:0]       tcnt_reg;
  logic [DIGITS-1:0]   hit, dv_reg, dv_next;
  logic [4*DIGITS-1:0] shadow_flat, value_reg;
  logic                strobe_reg, err_reg;

  // Two-flop synchronizers; they reset to the "all dark" level so that
  // reset release never looks like a multi-anode select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_reg <= '1;
      seg_s2_reg <= '1;
      an_s1_reg  <= '1;
      an_s2_reg  <= '1;
    end else begin
      seg_s1_reg <= seg;
      seg_s2_reg <= seg_s1_reg;
      an_s1_reg  <= anodes;
      an_s2_reg  <= an_s1_reg;
    end
  end

  // Classify the synchronized anode sample: blank, single digit, or illegal
  always_comb begin
    low_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_s2_reg[i]) begin
        low_cnt = low_cnt + CW'(1);
        sel_idx = KW'(i);
      end
    end
  end

  assign sample      = {an_s2_reg, seg_s2_reg};
  assign is_single   = (low_cnt == CW'(1));
  assign is_multi    = (low_cnt > CW'(1));
  assign sample_same = (sample == pair_reg);
  assign cnt_inc     = cnt_reg + 8'd1;

  // FSM next state: track dwell stability and capture once per dwell
  always_comb begin
    state_next = state_reg;
    pair_next  = pair_reg;
    k_next     = k_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    load       = 1'b0;
    case (state_reg)
      IDLE: load = is_single;
      SETTLE: begin
        if (sample_same) begin
          cnt_next = cnt_inc;
          if (cnt_inc >= STABLE_THR) state_next = CAPTURE;
        end else if (is_single) begin
          load = 1'b1;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (!sample_same) begin
          if (is_single) load = 1'b1;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A new dwell counts its first sample immediately
    if (load) begin
      pair_next  = sample;
      k_next     = sel_idx;
      cnt_next   = 8'd1;
      state_next = (STABLE_CYCLES <= 1) ? CAPTURE : SETTLE;
    end
    // Multi-anode select aborts whatever is in progress
    if (is_multi) begin
      cnt_next   = '0;
      state_next = IDLE;
    end
  end

  // FSM state and dwell registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pair_reg  <= '0;
      k_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pair_reg  <= pair_next;
      k_reg     <= k_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign dec         = seg_decode(pair_reg[6:0]);
  assign cap_ok      = capture && dec[4];
  assign err_set     = is_multi || (capture && !dec[4]);
  assign frame_done  = &dv_reg;
  assign timeout_hit = (tcnt_reg == TIMEOUT_VAL);

  // Per-digit shadow nibble, written only by a legal capture of that digit
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] shadow_reg;

    assign hit[gi] = cap_ok && (k_reg == KW'(gi));
    assign shadow_flat[4*gi +: 4] = shadow_reg;

    // Shadow store for this digit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       shadow_reg <= 4'h0;
      else if (hit[gi]) shadow_reg <= dec[3:0];
    end
  end

  // Valid flags clear on frame publish or timeout; a fresh capture still lands
  always_comb begin
    dv_next = (frame_done || timeout_hit) ? '0 : dv_reg;
    dv_next = dv_next | hit;
  end

  // Frame publish, timeout counting and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_reg     <= '0;
      value_reg  <= '0;
      strobe_reg <= 1'b0;
      err_reg    <= 1'b0;
      tcnt_reg   <= '0;
    end else begin
      dv_reg     <= dv_next;
      strobe_reg <= frame_done;
      if (frame_done) value_reg <= shadow_flat;
      if (capture)           tcnt_reg <= '0;
      else if (!timeout_hit) tcnt_reg <= tcnt_reg + TW'(1);
      if (err_set)      err_reg <= 1'b1;
      else if (err_clr) err_reg <= 1'b0;
    end
  end

  assign value        = value_reg;
  assign frame_strobe = strobe_reg;
  assign digit_valid  = dv_reg;
  assign decode_err   = err_reg;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: directed scenarios plus randomized digit
// dwells checked against a dwell-level behavioural model.
module tb_seven_seg_capture;
  localparam int DIGITS  = 4;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  anodes = 4'hF;
  logic        err_clr = 1'b0;
  logic [15:0] value;
  logic        frame_strobe;
  logic [3:0]  digit_valid;
  logic        decode_err;

  always #5 clk = ~clk;

  seven_seg_capture #(
    .DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .anodes(anodes),
    .value(value), .frame_strobe(frame_strobe), .digit_valid(digit_valid),
    .decode_err(decode_err), .err_clr(err_clr)
  );

  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = -1;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_strobe) begin
    strobe_cnt++;
    last_strobe_cyc = cyc;
  end

  // Reference model state
  logic [6:0]  seg_tab [16];
  logic [3:0]  m_shadow [4];
  logic [3:0]  m_dv;
  logic [15:0] m_value;
  logic        m_err;
  int          m_strobes;
  int          last_item_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic int decode_ref(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_shadow[i] = 4'h0;
    m_dv = 4'h0;
    m_value = 16'h0;
    m_err = 1'b0;
  endfunction

  // One dwell: a pair held for `hold` cycles that differs from its neighbours
  function automatic void model_item(input logic [3:0] an, input logic [6:0] sg, input int hold);
    int zeros;
    int k;
    int d;
    zeros = $countones(~an);
    k = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) k = i;
    if (zeros > 1) begin
      m_err = 1'b1;
    end else if (zeros == 1 && hold >= STABLE) begin
      d = decode_ref(sg);
      if (d < 0) begin
        m_err = 1'b1;
      end else begin
        m_shadow[k] = 4'(d);
        m_dv[k] = 1'b1;
        if (m_dv == 4'hF) begin
          m_value = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
          m_strobes++;
          m_dv = 4'h0;
        end
      end
    end
  endfunction

  task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
    repeat (n) begin
      anodes = an;
      seg = sg;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic item(input logic [3:0] an, input logic [6:0] sg, input int hold);
    last_item_start = cyc;
    model_item(an, sg, hold);
    drive(an, sg, hold);
  endtask

  task automatic scan_word(input logic [15:0] w, input int ndig);
    logic [3:0] an;
    for (int i = 0; i < ndig; i++) begin
      an = ~(4'b0001 << i);
      item(an, seg_tab[w[4*i +: 4]], 8);
      drive(4'hF, 7'h7F, 2);
    end
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    check({tag, "_dv"},     32'(digit_valid), 32'(m_dv));
    check({tag, "_value"},  32'(value),       32'(m_value));
    check({tag, "_err"},    32'(decode_err),  32'(m_err));
    check({tag, "_strobe"}, strobe_cnt,       m_strobes);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_err = 1'b0;
  endtask

  logic [3:0]  r_an, prev_an;
  logic [6:0]  r_sg, prev_sg;
  int          kind, hold, s0;
  logic [15:0] saved_value;

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
    seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
    seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
    seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
    model_reset();
    m_strobes = 0;
    last_item_start = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_value",  32'(value),        32'h0);
    check("rst_dv",     32'(digit_valid),  32'h0);
    check("rst_err",    32'(decode_err),   32'h0);
    check("rst_strobe", 32'(frame_strobe), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'hF, 7'h7F, 2);

    // Scan 1,2,3,4 -> one frame of 4321; strobe 8 cycles after last digit starts
    scan_word(16'h4321, 4);
    s0 = last_item_start;
    drive(4'hF, 7'h7F, 10);
    check("scan_value_const", 32'(value), 32'h4321);
    check("scan_strobe_lat", last_strobe_cyc - s0, 8);
    check_all("scan");

    // Digit held one cycle short of the stability window
    item(4'b1110, 7'b0000001, 3);
    drive(4'hF, 7'h7F, 10);
    check_all("short");

    // Two anodes low at once
    item(4'b1100, 7'b0000001, 5);
    drive(4'hF, 7'h7F, 10);
    check_all("multi");
    clear_err();
    check_all("multi_clr");

    // All segments dark on digit 2 is not a legal digit
    item(4'b1011, 7'b1111111, 10);
    drive(4'hF, 7'h7F, 10);
    check_all("illegal");
    check("illegal_dv2", 32'(digit_valid[2]), 32'h0);
    clear_err();

    // err_clr in the same cycle as a new error: the error wins
    anodes = 4'b1100; seg = 7'h7F;
    @(posedge clk); #1;
    anodes = 4'hF;
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err = 1'b1;
    drive(4'hF, 7'h7F, 4);
    check_all("setwins");
    clear_err();
    check_all("setwins_clr");

    // Partial frame then silence past the timeout
    saved_value = m_value;
    scan_word(16'h0765, 3);
    drive(4'hF, 7'h7F, 10);
    check_all("to_pre");
    drive(4'hF, 7'h7F, TIMEOUT - 120);
    check_all("to_mid");
    drive(4'hF, 7'h7F, 200);
    m_dv = 4'h0;
    check_all("to_post");
    check("to_value_kept", 32'(value), 32'(saved_value));

    // Full FACE frame, then reset partway into the next scan
    scan_word(16'hFACE, 4);
    drive(4'hF, 7'h7F, 10);
    check_all("face");
    scan_word(16'h1234, 2);
    drive(4'hF, 7'h7F, 1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_value", 32'(value),       32'h0);
    check("midrst_dv",    32'(digit_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(4'hF, 7'h7F, 2);
    scan_word(16'h0B0D, 4);
    drive(4'hF, 7'h7F, 10);
    check("rescan_value_const", 32'(value), 32'h0B0D);
    check_all("rescan");

    // Randomized dwells; holds never equal the stability window exactly
    prev_an = 4'hF;
    prev_sg = 7'h7F;
    for (int sgi = 0; sgi < 30; sgi++) begin
      for (int it = 0; it < 6; it++) begin
        do begin
          kind = $urandom_range(0, 19);
          if (kind == 0) begin
            r_an = 4'hF;
            r_sg = 7'($urandom);
          end else if (kind == 1) begin
            do r_an = 4'($urandom); while ($countones(~r_an) < 2);
            r_sg = 7'($urandom);
          end else begin
            r_an = ~(4'b0001 << $urandom_range(0, 3));
            if (kind == 2) begin
              do r_sg = 7'($urandom); while (decode_ref(r_sg) >= 0);
            end else begin
              r_sg = seg_tab[$urandom_range(0, 15)];
            end
          end
        end while ({r_an, r_sg} == {prev_an, prev_sg});
        hold = ($urandom_range(0, 1) == 0) ? $urandom_range(1, STABLE - 1)
                                           : $urandom_range(STABLE + 1, STABLE + 8);
        item(r_an, r_sg, hold);
        prev_an = r_an;
        prev_sg = r_sg;
      end
      drive(4'hF, 7'h7F, 12);
      prev_an = 4'hF;
      prev_sg = 7'h7F;
      check_all($sformatf("rand%0d", sgi));
      clear_err();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
